tadc_conv_sequencer: RTL
========================

Name: tadc_conv_sequencer

Overview:
Conversion controller for the on-chip time-based ADC (TADC) analog front end.
- Scans the enabled analog channels and, for each one, discharges the integrator, releases the ramp, and counts clock cycles until the comparator trips.
- Optionally averages 2^N conversions per channel, then presents one result per channel on a valid/ready interface.
- Sits between the digital wrapper (ui_in/uo_out/uio) and the analog macro on ua[5:0].

Parameters:
- NCH, 4, number of analog channels (≤6).
- CNT_W, 10, conversion counter width; MAX = 2^CNT_W-1.
- SETTLE_CYC, 8, discharge/settle cycles before each ramp; must be ≥ SYNC_STAGES+1.
- SYNC_STAGES, 2, comparator synchronizer depth (≥2).

Ports:
- clk, in, 1, single system clock.
- rst, in, 1, synchronous, active-high reset.
- start, in, 1, one-cycle pulse; begins a scan (ignored unless IDLE).
- cont, in, 1, continuous mode; sampled at each scan end.
- ch_mask, in, NCH, enabled channels; captured on accepted start.
- avg_log2, in, 2, samples per channel = 1<<avg_log2; captured on accepted start.
- comp_async, in, 1, asynchronous comparator output from the AFE.
- afe_sel, out, NCH, one-hot channel mux select.
- afe_discharge, out, 1, integrator reset to the AFE.
- afe_ramp_en, out, 1, ramp/integrate enable.
- res_data, out, CNT_W, averaged count.
- res_ch, out, clog2(NCH), channel index of the result.
- res_ovf, out, 1, at least one sample timed out.
- res_valid, out, 1, result available.
- res_ready, in, 1, consumer accepts the result.
- busy, out, 1, high whenever state ≠ IDLE.

Behaviour:
- Reset: state=IDLE. afe_sel=0, afe_discharge=1, afe_ramp_en=0, res_*=0, res_valid=0, busy=0. Synchronizer flops and all counters are cleared.
- Reset mid-operation returns to IDLE on the next edge. Any pending result is dropped.
- States: IDLE, SELECT, SETTLE, RAMP, ACCUM, OUTPUT.
- IDLE:
  - start=1 and ch_mask≠0: capture mask, avg_log2, cont; go to SELECT with search pointer=0.
  - start with ch_mask=0: ignored.
- SELECT (1 cycle):
  - Choose the lowest enabled index ≥ pointer; afe_sel becomes one-hot of it; clear accumulator, sample count and ovf; go to SETTLE.
  - No channel left: if the captured cont=1, re-sample cont and restart with pointer=0; else go to IDLE.
  - cont deasserted mid-scan lets the current scan finish.
- SETTLE: afe_discharge=1 for exactly SETTLE_CYC cycles, then RAMP.
- RAMP:
  - afe_discharge=0, afe_ramp_en=1. Counter is 0 in the first RAMP cycle and increments by 1 per cycle.
  - If comp_s=1, capture the counter value and go to ACCUM.
  - Else if counter==MAX, capture MAX, set ovf and go to ACCUM.
  - comp_s is the last synchronizer stage. Comparator high before integration completes (count 0..SYNC_STAGES) is reported as-is.
  - Latency rule: comp_async high from counter value j ⇒ captured value j+SYNC_STAGES.
- ACCUM (1 cycle):
  - Accumulator (CNT_W+3 bits) += captured value.
  - If sample count+1 < 1<<avg_log2, go to SETTLE (same channel); else go to OUTPUT.
- OUTPUT:
  - On entry: res_data = accumulator >> avg_log2 (truncating), plus res_ch, res_ovf; res_valid=1; afe_discharge=1.
  - Outputs stay stable while res_valid=1 and res_ready=0.
  - On the valid&ready cycle, res_valid drops next cycle, pointer=current+1, go to SELECT.
- afe_sel holds the channel from SELECT through OUTPUT and is 0 in IDLE.
- afe_ramp_en is asserted only in RAMP.
- start while busy has no effect.
- Single-channel mask with cont=1 repeats that channel indefinitely.
- Per-sample cycle budget: SETTLE_CYC + (count+1) + 1, plus 1 SELECT cycle per channel, plus OUTPUT wait.

Decomposition:
- Package tadc_pkg: state enum, default CNT_W/NCH, and the ACC_W = CNT_W+3 constant.
- One sub-module, tadc_sync, a SYNC_STAGES-deep synchronizer with synchronous clear, instantiated for comp_async.
- Channel priority search and FSM stay in the top level.

Test Plan:
- Single conversion: NCH=4, mask=0001, avg_log2=0, comp_async rises at counter 98 → one result, res_data=100, res_ch=0, res_ovf=0. afe_ramp_en high exactly 101 cycles; busy drops after the handshake.
- Scan order/backpressure: mask=1010, comp trips at count 10 then 20 → results ch1 (12) then ch3 (22). res_ready held low 5 cycles: res_data stable, no new SETTLE starts.
- Averaging: avg_log2=2, trip counts 8,9,10,11 (captured 10,11,12,13) → res_data=11 (46>>2), four RAMP windows each preceded by 8 discharge cycles.
- Timeout: comp_async held 0 → res_data=1023, res_ovf=1. With avg_log2=1 and the second sample tripping at 98 (captured 100): res_data=561, res_ovf=1.
- Continuous mode: cont=1, mask=0100 → back-to-back results on ch2. cont dropped mid-conversion → exactly one more result, then IDLE.
- Reset and start edge cases:
  - rst asserted during RAMP → next cycle: IDLE, afe_discharge=1, ramp_en=0, res_valid=0.
  - start with mask=0 → busy stays 0.
  - start while busy → ignored.

Source files
------------

// File: rtl/tadc_conv_sequencer_pkg.sv
// Shared types and constants for the TADC conversion sequencer.
package tadc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_SETTLE,
    S_RAMP,
    S_ACCUM,
    S_OUTPUT
  } state_t;

  localparam int DEF_NCH   = 4;
  localparam int DEF_CNT_W = 10;
  // Three guard bits hold the sum of up to 8 full-scale samples.
  localparam int ACC_GUARD = 3;
  localparam int ACC_W     = DEF_CNT_W + ACC_GUARD;

endpackage

// File: rtl/tadc_conv_sequencer_sync.sv
// Multi-flop synchronizer with synchronous clear for the comparator input.
module tadc_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (clr) ff <= '0;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/tadc_conv_sequencer.sv
// Time-based ADC conversion sequencer: channel scan, ramp timing,
// optional 2^N averaging and a valid/ready result port.
module tadc_conv_sequencer
  import tadc_pkg::*;
#(
  parameter int NCH         = DEF_NCH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SETTLE_CYC  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   cont,
  input  logic [NCH-1:0]         ch_mask,
  input  logic [1:0]             avg_log2,
  input  logic                   comp_async,
  output logic [NCH-1:0]         afe_sel,
  output logic                   afe_discharge,
  output logic                   afe_ramp_en,
  output logic [CNT_W-1:0]       res_data,
  output logic [$clog2(NCH)-1:0] res_ch,
  output logic                   res_ovf,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic                   busy
);

  localparam int CH_W = $clog2(NCH);
  localparam int PW   = CH_W + 1;
  localparam int AW   = CNT_W + ACC_GUARD;
  localparam int SW   = $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0] MAXC = '1;

  state_t          state;
  logic [NCH-1:0]  mask_q;
  logic [1:0]      avg_q;
  logic            cont_q;
  logic [PW-1:0]   ptr;
  logic [CH_W-1:0] cur;
  logic [AW-1:0]   acc;
  logic [2:0]      nsamp;
  logic [SW-1:0]   settle_cnt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] samp;
  logic            ovf;
  logic            comp_s;
  logic            found;
  logic [CH_W-1:0] pick;
  logic [AW-1:0]   acc_sum;
  logic            last;

  tadc_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .clr (rst),
    .d   (comp_async),
    .q   (comp_s)
  );

  // Lowest enabled channel at or above the search pointer.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = NCH-1; i >= 0; i--) begin
      if (mask_q[i] && PW'(i) >= ptr) begin
        found = 1'b1;
        pick  = CH_W'(i);
      end
    end
  end

  assign acc_sum = acc + {{(AW-CNT_W){1'b0}}, samp};
  assign last    = ({1'b0, nsamp} + 4'd1) >= (4'd1 << avg_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      afe_sel       <= '0;
      afe_discharge <= 1'b1;
      afe_ramp_en   <= 1'b0;
      res_data      <= '0;
      res_ch        <= '0;
      res_ovf       <= 1'b0;
      res_valid     <= 1'b0;
      busy          <= 1'b0;
      mask_q        <= '0;
      avg_q         <= '0;
      cont_q        <= 1'b0;
      ptr           <= '0;
      cur           <= '0;
      acc           <= '0;
      nsamp         <= '0;
      settle_cnt    <= '0;
      cnt           <= '0;
      samp          <= '0;
      ovf           <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && ch_mask != '0) begin
            mask_q <= ch_mask;
            avg_q  <= avg_log2;
            cont_q <= cont;
            ptr    <= '0;
            busy   <= 1'b1;
            state  <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (found) begin
            afe_sel    <= NCH'(1) << pick;
            cur        <= pick;
            acc        <= '0;
            nsamp      <= '0;
            ovf        <= 1'b0;
            settle_cnt <= '0;
            state      <= S_SETTLE;
          end else if (cont_q && cont) begin
            // Continue only while cont is still high at the scan boundary,
            // so dropping it mid-scan lets just the current scan finish.
            cont_q <= cont;
            ptr    <= '0;
          end else begin
            cont_q  <= 1'b0;
            afe_sel <= '0;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == SW'(SETTLE_CYC - 1)) begin
            afe_discharge <= 1'b0;
            afe_ramp_en   <= 1'b1;
            cnt           <= '0;
            state         <= S_RAMP;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        S_RAMP: begin
          if (comp_s) begin
            samp        <= cnt;
            afe_ramp_en <= 1'b0;
            state       <= S_ACCUM;
          end else if (cnt == MAXC) begin
            samp        <= MAXC;
            ovf         <= 1'b1;
            afe_ramp_en <= 1'b0;
            state       <= S_ACCUM;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ACCUM: begin
          acc           <= acc_sum;
          afe_discharge <= 1'b1;
          if (last) begin
            res_data  <= CNT_W'(acc_sum >> avg_q);
            res_ch    <= cur;
            res_ovf   <= ovf;
            res_valid <= 1'b1;
            state     <= S_OUTPUT;
          end else begin
            nsamp      <= nsamp + 3'd1;
            settle_cnt <= '0;
            state      <= S_SETTLE;
          end
        end
        S_OUTPUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            ptr       <= PW'(cur) + PW'(1);
            state     <= S_SELECT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
